// File: rtl/ysyx_22040931_mem_arb.sv
`default_nettype none
// ============================================================================
// Module   : ysyx_22040931_mem_arb
// Brief    : Two-requester (fetch / load-store) arbiter onto a single
//            request/response bus, with starvation guard for fetch.
// Revision : 1.0 - initial release
// ============================================================================
module ysyx_22040931_mem_arb #(
  parameter int STARVE_MAX = 4
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        if_req_valid,
  output logic        if_req_ready,
  input  logic [63:0] if_addr,
  output logic        if_rsp_valid,
  output logic [31:0] if_rsp_instr,
  input  logic        mem_req_valid,
  output logic        mem_req_ready,
  input  logic        mem_req_wr,
  input  logic [63:0] mem_req_addr,
  input  logic [63:0] mem_req_wdata,
  input  logic [7:0]  mem_req_wmask,
  output logic        mem_rsp_valid,
  output logic [63:0] mem_rsp_rdata,
  output logic        bus_req_valid,
  input  logic        bus_req_ready,
  output logic        bus_wr,
  output logic [63:0] bus_addr,
  output logic [63:0] bus_wdata,
  output logic [7:0]  bus_wmask,
  input  logic        bus_rsp_valid,
  input  logic [63:0] bus_rsp_data
);

  localparam logic [2:0] c_starve_max = 3'(STARVE_MAX);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_WAIT = 2'd2,
    S_RESP = 2'd3
  } state_t;

  state_t     r_state;
  state_t     w_state_nxt;
  logic       r_owner_mem;
  logic [2:0] r_starve_cnt;
  logic       w_if_win;
  logic       w_mem_win;

  // MEM has priority unless fetch has waited through STARVE_MAX MEM grants
  assign w_if_win  = if_req_valid & (~mem_req_valid | (r_starve_cnt == c_starve_max));
  assign w_mem_win = mem_req_valid & ~w_if_win;

  always_comb begin
    w_state_nxt   = r_state;
    if_req_ready  = 1'b0;
    mem_req_ready = 1'b0;
    case (r_state)
      S_IDLE: begin
        // readies must stay low while reset is held, even though state is IDLE
        if (reset) begin
          if_req_ready  = w_if_win;
          mem_req_ready = w_mem_win;
          if (w_if_win | w_mem_win) w_state_nxt = S_REQ;
        end
      end
      S_REQ:   if (bus_req_ready) w_state_nxt = S_WAIT;
      S_WAIT:  if (bus_rsp_valid) w_state_nxt = S_RESP;
      S_RESP:  w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  assign bus_req_valid = (r_state == S_REQ);
  assign if_rsp_valid  = (r_state == S_RESP) & ~r_owner_mem;
  assign mem_rsp_valid = (r_state == S_RESP) & r_owner_mem;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) r_state <= S_IDLE;
    else        r_state <= w_state_nxt;
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_owner_mem   <= 1'b0;
      r_starve_cnt  <= 3'd0;
      bus_wr        <= 1'b0;
      bus_addr      <= 64'd0;
      bus_wdata     <= 64'd0;
      bus_wmask     <= 8'd0;
      if_rsp_instr  <= 32'd0;
      mem_rsp_rdata <= 64'd0;
    end else begin
      if (if_req_ready) begin
        r_owner_mem  <= 1'b0;
        bus_wr       <= 1'b0;
        bus_addr     <= if_addr;
        bus_wdata    <= 64'd0;
        bus_wmask    <= 8'd0;
        r_starve_cnt <= 3'd0;
      end else if (mem_req_ready) begin
        r_owner_mem <= 1'b1;
        bus_wr      <= mem_req_wr;
        bus_addr    <= mem_req_addr;
        bus_wdata   <= mem_req_wdata;
        bus_wmask   <= mem_req_wmask;
        if (if_req_valid && (r_starve_cnt != 3'd7)) r_starve_cnt <= r_starve_cnt + 3'd1;
      end
      // Response data lands directly in the output registers so it holds between pulses
      if ((r_state == S_WAIT) && bus_rsp_valid) begin
        if (r_owner_mem) mem_rsp_rdata <= bus_wr ? 64'd0 : bus_rsp_data;
        else             if_rsp_instr  <= bus_addr[2] ? bus_rsp_data[63:32] : bus_rsp_data[31:0];
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_ysyx_22040931_mem_arb.sv
`default_nettype none
// ============================================================================
// Module   : tb_ysyx_22040931_mem_arb
// Brief    : Self-checking bench for the fetch/load-store bus arbiter.
// Revision : 1.0 - initial release
// ============================================================================
module tb_ysyx_22040931_mem_arb;

  localparam int STARVE_MAX = 4;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        if_req_valid = 1'b0;
  logic        if_req_ready;
  logic [63:0] if_addr = '0;
  logic        if_rsp_valid;
  logic [31:0] if_rsp_instr;
  logic        mem_req_valid = 1'b0;
  logic        mem_req_ready;
  logic        mem_req_wr = 1'b0;
  logic [63:0] mem_req_addr = '0;
  logic [63:0] mem_req_wdata = '0;
  logic [7:0]  mem_req_wmask = '0;
  logic        mem_rsp_valid;
  logic [63:0] mem_rsp_rdata;
  logic        bus_req_valid;
  logic        bus_req_ready = 1'b0;
  logic        bus_wr;
  logic [63:0] bus_addr;
  logic [63:0] bus_wdata;
  logic [7:0]  bus_wmask;
  logic        bus_rsp_valid = 1'b0;
  logic [63:0] bus_rsp_data = '0;

  ysyx_22040931_mem_arb #(.STARVE_MAX(STARVE_MAX)) dut (
    .clock(clock), .reset(reset),
    .if_req_valid(if_req_valid), .if_req_ready(if_req_ready), .if_addr(if_addr),
    .if_rsp_valid(if_rsp_valid), .if_rsp_instr(if_rsp_instr),
    .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready), .mem_req_wr(mem_req_wr),
    .mem_req_addr(mem_req_addr), .mem_req_wdata(mem_req_wdata), .mem_req_wmask(mem_req_wmask),
    .mem_rsp_valid(mem_rsp_valid), .mem_rsp_rdata(mem_rsp_rdata),
    .bus_req_valid(bus_req_valid), .bus_req_ready(bus_req_ready), .bus_wr(bus_wr),
    .bus_addr(bus_addr), .bus_wdata(bus_wdata), .bus_wmask(bus_wmask),
    .bus_rsp_valid(bus_rsp_valid), .bus_rsp_data(bus_rsp_data)
  );

  always #5 clock = ~clock;

  int n_assert = 0;
  int n_fail   = 0;

  // transaction-level reference state
  bit          m_busy, m_req_phase, m_rsp_due, m_owner_mem, m_wr;
  logic [63:0] m_addr, m_wdata;
  logic [7:0]  m_wmask;
  int          m_starve, busy_cycles;
  bit          if_pend, mem_pend;
  bit          r_in_wait;
  int          r_dly;
  bit          g_q[$];
  bit          rsp_q[$];
  int p_if, p_mem, p_drop, p_rdy, max_dly, p_spur, p_wr;

  function automatic logic [63:0] bus_model(input logic [63:0] a);
    return {a[31:0] ^ 32'hA5A5_5A5A, ~a[31:0]};
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic do_reset();
    @(negedge clock);
    reset = 1'b0;
    if_req_valid  = 1'b1;
    mem_req_valid = 1'b1;
    bus_req_ready = 1'b0;
    bus_rsp_valid = 1'b0;
    #1;
    chk("rst_if_ready",  64'(if_req_ready), 64'd0);
    chk("rst_mem_ready", 64'(mem_req_ready), 64'd0);
    chk("rst_bus_valid", 64'(bus_req_valid), 64'd0);
    chk("rst_rsp_valid", 64'({if_rsp_valid, mem_rsp_valid}), 64'd0);
    chk("rst_bus_fields", bus_addr | bus_wdata | 64'(bus_wmask) | 64'(bus_wr), 64'd0);
    chk("rst_rsp_data", mem_rsp_rdata | 64'(if_rsp_instr), 64'd0);
    @(posedge clock);
    @(negedge clock);
    if_req_valid  = 1'b0;
    mem_req_valid = 1'b0;
    reset = 1'b1;
    m_busy = 0; m_req_phase = 0; m_rsp_due = 0; m_starve = 0; busy_cycles = 0;
    if_pend = 0; mem_pend = 0; r_in_wait = 0;
    g_q.delete(); rsp_q.delete();
  endtask

  // one clock cycle of random requesters + bus responder, checked against the model
  task automatic step();
    logic [63:0] exp;
    bit          new_due;
    bit          e_if, e_mem;
    new_due = 0;
    @(negedge clock);
    chk("if_rsp_valid",  64'(if_rsp_valid),  64'(m_rsp_due && !m_owner_mem));
    chk("mem_rsp_valid", 64'(mem_rsp_valid), 64'(m_rsp_due && m_owner_mem));
    if (m_rsp_due) begin
      exp = bus_model(m_addr);
      rsp_q.push_back(m_owner_mem);
      if (!m_owner_mem) chk("if_rsp_instr", 64'(if_rsp_instr), 64'(m_addr[2] ? exp[63:32] : exp[31:0]));
      else              chk("mem_rsp_rdata", mem_rsp_rdata, m_wr ? 64'd0 : exp);
    end
    if (!if_pend && ($urandom % 100 < p_if)) begin
      if_pend = 1;
      if_addr = {32'h8000_0000 | 32'($urandom_range(0, 255)), $urandom & 32'hFFFF_FFFC};
    end else if (if_pend && ($urandom % 100 < p_drop)) if_pend = 0;
    if_req_valid = if_pend;
    if (!mem_pend && ($urandom % 100 < p_mem)) begin
      mem_pend      = 1;
      mem_req_wr    = ($urandom % 100) < p_wr;
      mem_req_addr  = {$urandom, $urandom};
      mem_req_wdata = {$urandom, $urandom};
      mem_req_wmask = 8'($urandom);
    end else if (mem_pend && ($urandom % 100 < p_drop)) mem_pend = 0;
    mem_req_valid = mem_pend;
    chk("bus_req_valid", 64'(bus_req_valid), 64'(m_req_phase));
    if (m_req_phase) begin
      chk("bus_addr",  bus_addr, m_addr);
      chk("bus_wr",    64'(bus_wr), 64'(m_wr));
      chk("bus_wdata", bus_wdata, m_wdata);
      chk("bus_wmask", 64'(bus_wmask), 64'(m_wmask));
    end
    if (r_in_wait) begin
      if (r_dly == 0) begin
        bus_rsp_valid = 1'b1;
        bus_rsp_data  = bus_model(m_addr);
        r_in_wait = 0;
        new_due   = 1;
      end else begin
        r_dly--;
        bus_rsp_valid = 1'b0;
      end
    end else begin
      bus_rsp_valid = ($urandom % 100) < p_spur;
      bus_rsp_data  = {$urandom, $urandom};
    end
    bus_req_ready = ($urandom % 100) < p_rdy;
    if (m_req_phase && bus_req_ready) begin
      r_in_wait   = 1;
      r_dly       = $urandom_range(0, max_dly);
      m_req_phase = 0;
    end
    #1;
    e_if  = !m_busy && if_pend && (!mem_pend || m_starve == STARVE_MAX);
    e_mem = !m_busy && mem_pend && !e_if;
    chk("if_req_ready",  64'(if_req_ready),  64'(e_if));
    chk("mem_req_ready", 64'(mem_req_ready), 64'(e_mem));
    if (e_if || e_mem) begin
      m_busy = 1; m_req_phase = 1; m_owner_mem = e_mem; busy_cycles = 0;
      g_q.push_back(e_mem);
      if (e_if) begin
        m_addr = if_addr; m_wr = 0; m_wdata = '0; m_wmask = '0;
        m_starve = 0; if_pend = 0;
      end else begin
        m_addr = mem_req_addr; m_wr = mem_req_wr; m_wdata = mem_req_wdata; m_wmask = mem_req_wmask;
        if (if_pend) m_starve = (m_starve + 1 > 7) ? 7 : m_starve + 1;
        mem_pend = 0;
      end
    end
    if (m_rsp_due) begin
      m_rsp_due = 0;
      m_busy    = 0;
    end
    if (new_due) m_rsp_due = 1;
    if (m_busy) begin
      busy_cycles++;
      chk("txn_timeout", 64'(busy_cycles > 60), 64'd0);
    end
  endtask

  // lone fetch with the fastest bus, accept to response in exactly three cycles
  task automatic lone_if(input logic [63:0] a, input logic [63:0] d, input logic [31:0] e);
    @(negedge clock);
    if_req_valid = 1'b1;
    if_addr = a;
    #1;
    chk("lone_if_ready", 64'({if_req_ready, mem_req_ready}), 64'd2);
    @(negedge clock);
    if_req_valid  = 1'b0;
    bus_req_ready = 1'b1;
    #1;
    chk("lone_bus_valid", 64'(bus_req_valid), 64'd1);
    chk("lone_bus_addr", bus_addr, a);
    chk("lone_bus_zero", bus_wdata | 64'(bus_wmask) | 64'(bus_wr), 64'd0);
    @(negedge clock);
    bus_req_ready = 1'b0;
    bus_rsp_valid = 1'b1;
    bus_rsp_data  = d;
    chk("lone_early_rsp", 64'(if_rsp_valid), 64'd0);
    @(negedge clock);
    bus_rsp_valid = 1'b0;
    chk("lone_rsp_valid", 64'({if_rsp_valid, mem_rsp_valid}), 64'd2);
    chk("lone_rsp_instr", 64'(if_rsp_instr), 64'(e));
    @(negedge clock);
    chk("lone_rsp_pulse", 64'(if_rsp_valid), 64'd0);
    chk("lone_instr_hold", 64'(if_rsp_instr), 64'(e));
  endtask

  initial begin
    p_if = 0; p_mem = 0; p_drop = 0; p_rdy = 100; max_dly = 0; p_spur = 0; p_wr = 0;
    do_reset();

    lone_if(64'h8000_0004, 64'h1111_2222_3333_4444, 32'h1111_2222);

    // spurious bus response while idle
    @(negedge clock);
    bus_rsp_valid = 1'b1;
    bus_rsp_data  = 64'hFFFF_0000_FFFF_0000;
    repeat (3) begin
      @(negedge clock);
      chk("spur_rsp_valid", 64'({if_rsp_valid, mem_rsp_valid, bus_req_valid}), 64'd0);
      chk("spur_instr", 64'(if_rsp_instr), 64'h1111_2222);
    end
    bus_rsp_valid = 1'b0;

    // store with a stalled bus
    @(negedge clock);
    mem_req_valid = 1'b1; mem_req_wr = 1'b1; mem_req_addr = 64'h8000_0010;
    mem_req_wmask = 8'h0F; mem_req_wdata = 64'hDEAD_BEEF;
    #1;
    chk("st_ready", 64'({if_req_ready, mem_req_ready}), 64'd1);
    for (int i = 0; i < 4; i++) begin
      @(negedge clock);
      mem_req_valid = 1'b0;
      mem_req_addr  = '1;
      bus_req_ready = (i == 3);
      chk("st_bus_valid", 64'(bus_req_valid), 64'd1);
      chk("st_bus_fields", {bus_addr[31:0], bus_wdata[31:0]}, 64'h8000_0010_DEAD_BEEF);
      chk("st_bus_ctl", 64'({bus_wr, bus_wmask}), 64'h10F);
    end
    @(negedge clock);
    bus_req_ready = 1'b0;
    bus_rsp_valid = 1'b1;
    bus_rsp_data  = 64'h1234_5678_9ABC_DEF0;
    @(negedge clock);
    bus_rsp_valid = 1'b0;
    chk("st_rsp_valid", 64'({if_rsp_valid, mem_rsp_valid}), 64'd1);
    chk("st_rsp_rdata", mem_rsp_rdata, 64'd0);
    @(negedge clock);
    chk("st_rsp_pulse", 64'(mem_rsp_valid), 64'd0);

    // reset while waiting on the bus, then a stray response
    @(negedge clock);
    if_req_valid = 1'b1; if_addr = 64'h8000_0100;
    @(negedge clock);
    if_req_valid = 1'b0; bus_req_ready = 1'b1;
    @(negedge clock);
    bus_req_ready = 1'b0;
    reset = 1'b0;
    #1;
    chk("wrst_bus_valid", 64'(bus_req_valid), 64'd0);
    chk("wrst_bus_addr", bus_addr, 64'd0);
    @(negedge clock);
    reset = 1'b1;
    bus_rsp_valid = 1'b1;
    bus_rsp_data  = 64'hBAD0_BAD0_BAD0_BAD0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clock);
      bus_rsp_valid = 1'b0;
      chk("wrst_no_rsp", 64'({if_rsp_valid, mem_rsp_valid, bus_req_valid}), 64'd0);
      chk("wrst_instr", 64'(if_rsp_instr), 64'd0);
    end
    lone_if(64'h8000_0200, 64'hCAFE_F00D_0BAD_BEEF, 32'h0BAD_BEEF);

    // simultaneous fetch and load after reset: MEM first, IF second
    do_reset();
    p_if = 100; p_mem = 100;
    step();
    p_if = 0; p_mem = 0;
    repeat (12) step();
    chk("both_grants", 64'(g_q.size()), 64'd2);
    chk("both_first_mem", 64'(g_q[0]), 64'd1);
    chk("both_second_if", 64'(g_q[1]), 64'd0);
    chk("both_rsp_order", 64'({rsp_q[0], rsp_q[1]}), 64'd2);

    // starvation: fetch held valid against back-to-back MEM traffic
    do_reset();
    p_if = 100; p_mem = 100; p_wr = 50;
    repeat (45) step();
    chk("starve_grants", 64'(g_q.size() >= 10), 64'd1);
    for (int i = 0; i < 10; i++)
      chk($sformatf("starve_grant%0d", i), 64'(g_q[i]), 64'((i % 5) != 4));

    // random traffic
    do_reset();
    p_if = 40; p_mem = 40; p_drop = 10; p_rdy = 60; max_dly = 3; p_spur = 25; p_wr = 50;
    repeat (2000) step();
    chk("rand_traffic", 64'(g_q.size() > 100), 64'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/ysyx_22040931_mem_arb.md
YSYX_22040931_MEM_ARB -- requirements
Module: ysyx_22040931_mem_arb

Interface
REQ-001 SHALL have parameter STARVE_MAX, default 4, giving the consecutive MEM grants allowed while IF waits before IF is forced (range 1..7).
REQ-002 SHALL have one clock and an asynchronous, active-low reset; ports are listed below (name  direction  width  meaning).
REQ-003 clock  in  1  sole clock; all state changes on its rising edge.
REQ-004 reset  in  1  asynchronous, active-low reset.
REQ-005 if_req_valid  in  1  fetch read request.
REQ-006 if_req_ready  out  1  fetch request accepted this cycle.
REQ-007 if_addr  in  64  fetch address; 4-byte aligned.
REQ-008 if_rsp_valid  out  1  one-cycle pulse, fetch data valid.
REQ-009 if_rsp_instr  out  32  fetched instruction.
REQ-010 mem_req_valid  in  1  load/store request.
REQ-011 mem_req_ready  out  1  load/store request accepted.
REQ-012 mem_req_wr  in  1  1 = store, 0 = load.
REQ-013 mem_req_addr  in  64  load/store address.
REQ-014 mem_req_wdata  in  64  store data, already lane-aligned.
REQ-015 mem_req_wmask  in  8  store byte mask.
REQ-016 mem_rsp_valid  out  1  one-cycle pulse, load data valid or store done.
REQ-017 mem_rsp_rdata  out  64  load data; 0 for stores.
REQ-018 bus_req_valid / bus_req_ready  out / in  1 / 1  downstream request handshake.
REQ-019 bus_wr, bus_addr, bus_wdata, bus_wmask  out  1/64/64/8  downstream request fields.
REQ-020 bus_rsp_valid / bus_rsp_data  in  1 / 64  downstream response.

Function
REQ-021 SHALL use the FSM IDLE -> REQ -> WAIT -> RESP -> IDLE, with an owner register (IF or MEM).
REQ-022 In IDLE, SHALL assert if_req_ready or mem_req_ready combinationally, one at most, only for the winning valid requester; both SHALL be 0 in every other state.
REQ-023 Arbitration SHALL follow these rules:
- MEM wins when both requests are valid, unless starve_cnt == STARVE_MAX, in which case IF wins.
- A lone valid requester always wins.
REQ-024 starve_cnt (3-bit) SHALL update as follows:
- increment, saturating, on a MEM grant while if_req_valid = 1;
- clear on an IF grant;
- hold otherwise.
REQ-025 On accept (valid & ready), SHALL latch the owner and request fields into the bus registers and enter REQ the next cycle; an IF request SHALL go out as wr = 0, wmask = 0, wdata = 0.
REQ-026 In REQ, SHALL hold bus_req_valid = 1 with stable fields until bus_req_ready = 1, then enter WAIT.
REQ-027 In WAIT, on bus_rsp_valid = 1, SHALL capture bus_rsp_data and enter RESP.
REQ-028 bus_rsp_valid in IDLE, REQ or RESP SHALL be ignored.
REQ-029 In RESP, SHALL pulse the owner's rsp_valid for exactly one cycle, then return to IDLE; a new accept is possible in the following cycle.
REQ-030 if_rsp_instr SHALL be captured data [63:32] when latched addr[2] = 1, else [31:0]; mem_rsp_rdata SHALL be the full 64 bits for loads and 0 for stores.
REQ-031 Minimum latency, accept to rsp_valid, SHALL be 3 cycles, with bus_req_ready = 1 on the first REQ cycle and bus_rsp_valid on the first WAIT cycle.
REQ-032 SHALL allow at most one outstanding transaction; a requester SHALL hold valid and fields until ready (master obligation), and the arbiter samples fields only at accept.
REQ-033 A requester dropping valid before accept SHALL lose nothing and change no state.
REQ-034 Non-owner rsp_valid SHALL stay 0; rsp data outputs SHALL hold their last value between pulses.

Reset
REQ-035 While reset = 0, SHALL force state to IDLE and starve_cnt to 0, with all ready/valid outputs 0 and all data/address/mask outputs 0.
REQ-036 Reset asserted mid-transaction SHALL abandon it; a bus response arriving after reset release in IDLE SHALL be ignored per REQ-028.
REQ-037 After reset release, SHALL grant on the first clock edge on which a requester is valid.

Verification
REQ-038 Lone IF: if_addr = 0x8000_0004, bus returns 0x1111_2222_3333_4444 on the first WAIT cycle -> if_rsp_valid pulses at accept+3 with if_rsp_instr = 0x1111_2222.
REQ-039 Simultaneous IF + MEM load, STARVE_MAX = 4, fresh after reset -> MEM granted first, IF granted second; IF rsp arrives after MEM rsp.
REQ-040 Starvation: IF continuously valid with MEM requests back-to-back -> the first 4 grants go to MEM, the 5th to IF, then starve_cnt = 0.
REQ-041 Store: wr = 1, addr = 0x8000_0010, wmask = 0x0F, wdata = 0xDEAD_BEEF; bus_req_ready held 0 for 3 cycles -> bus fields stable throughout, mem_rsp_valid pulses once with mem_rsp_rdata = 0.
REQ-042 Reset pulse in WAIT, then a stray bus_rsp_valid -> no rsp_valid on either port, state IDLE, next IF request served normally.
REQ-043 Spurious bus_rsp_valid in IDLE with no requests -> no output change.
